// File: rtl/boa_stage_mem_if.sv
// Single-port data bus between the MEM stage (master) and data memory (slave).
// One access per cycle; an access completes in a cycle with bus_ready high.
interface boa_stage_mem_if;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:2] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_re,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ready
  );

  modport slave (
    input  bus_re,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ready
  );
endinterface

// File: rtl/boa_stage_mem.sv
// Boa32 MEM stage: holds the EX/MEM barrier, performs loads/stores on the data bus,
// aligns load data and raises access traps before handing results to writeback.
module boa_stage_mem (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,

  input  logic                  d_valid,
  input  logic [31:1]           d_pc,
  input  logic [31:0]           d_insn,
  input  logic                  d_use_rd,
  input  logic [31:0]           d_rs1_val,
  input  logic [31:0]           d_rs2_val,
  input  logic                  d_trap,
  input  logic [3:0]            d_cause,

  output logic                  q_valid,
  output logic [31:1]           q_pc,
  output logic [31:0]           q_insn,
  output logic                  q_use_rd,
  output logic [31:0]           q_rd_val,
  output logic                  q_trap,
  output logic [3:0]            q_cause,

  boa_stage_mem_if.master       bus,

  input  logic                  fw_stall_mem,
  output logic                  fw_rd,
  output logic                  stall_req
);

  localparam logic [4:0] OpLoad  = 5'b00000;
  localparam logic [4:0] OpStore = 5'b01000;

  typedef enum logic [0:0] {StIdle, StDone} state_e;

  state_e      state_q, state_d;
  logic        valid_q, use_rd_q, trap_q;
  logic [31:1] pc_q;
  logic [31:0] insn_q, rs1_val_q, rs2_val_q, hold_q;
  logic [3:0]  cause_q;
  logic        hold_en;

  logic        is_load, is_store, is_mem;
  logic [2:0]  funct3;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        misaligned, illegal, trap_any, req;
  logic [3:0]  we_mask;
  logic [31:0] wdata;
  logic [31:0] ld_src, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      trap_q    <= 1'b0;
      pc_q      <= '0;
      insn_q    <= '0;
      use_rd_q  <= 1'b0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      cause_q   <= '0;
      hold_q    <= '0;
    end else begin
      state_q <= state_d;
      if (!fw_stall_mem) begin
        valid_q   <= d_valid;
        pc_q      <= d_pc;
        insn_q    <= d_insn;
        use_rd_q  <= d_use_rd;
        rs1_val_q <= d_rs1_val;
        rs2_val_q <= d_rs2_val;
        trap_q    <= d_trap;
        cause_q   <= d_cause;
      end
      if (hold_en) begin
        hold_q <= bus.bus_rdata;
      end
    end
  end

  always_comb begin
    is_load    = insn_q[6:2] == OpLoad;
    is_store   = insn_q[6:2] == OpStore;
    is_mem     = is_load || is_store;
    funct3     = insn_q[14:12];
    size       = insn_q[13:12];
    addr       = rs1_val_q;
    misaligned = is_mem && (((size == 2'b10) && (addr[1:0] != 2'b00)) ||
                            ((size == 2'b01) && addr[0]));
    illegal    = (is_load && ((funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                 (is_store && funct3[2]);
    trap_any   = trap_q || illegal || misaligned;
    req        = valid_q && is_mem && !trap_any && !clear && (state_q == StIdle);
  end

  always_comb begin
    we_mask = 4'b1111;
    wdata   = rs2_val_q;
    case (size)
      2'b00: begin
        we_mask = 4'b0001 << addr[1:0];
        wdata   = {4{rs2_val_q[7:0]}};
      end
      2'b01: begin
        we_mask = 4'b0011 << addr[1:0];
        wdata   = {2{rs2_val_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Once the access has completed under a stall, the hold register stands in for the bus.
  always_comb begin
    ld_src  = (state_q == StDone) ? hold_q : bus.bus_rdata;
    ld_byte = ld_src[{addr[1:0], 3'b000} +: 8];
    ld_half = addr[1] ? ld_src[31:16] : ld_src[15:0];
    case (funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = ld_src;
    endcase
  end

  always_comb begin
    state_d = state_q;
    hold_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req && bus.bus_ready && fw_stall_mem) begin
          state_d = StDone;
          hold_en = 1'b1;
        end
      end
      StDone: begin
        if (clear || !fw_stall_mem) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.bus_re    = req && is_load;
    bus.bus_we    = (req && is_store) ? we_mask : 4'b0000;
    bus.bus_addr  = addr[31:2];
    bus.bus_wdata = wdata;

    stall_req = req && !bus.bus_ready;

    q_valid  = valid_q && !clear && !stall_req;
    q_pc     = pc_q;
    q_insn   = insn_q;
    q_use_rd = use_rd_q;
    q_rd_val = is_load ? ld_data : rs1_val_q;
    q_trap   = !clear && valid_q && trap_any;
    if (trap_q) begin
      q_cause = cause_q;
    end else if (illegal) begin
      q_cause = 4'd2;
    end else if (misaligned) begin
      q_cause = is_load ? 4'd4 : 4'd6;
    end else begin
      q_cause = cause_q;
    end

    fw_rd = valid_q && use_rd_q && !is_store &&
            (!is_load || bus.bus_ready || (state_q == StDone));
  end

endmodule

// File: tb/tb_boa_stage_mem.sv
// Self-checking bench for boa_stage_mem: retired results are scoreboarded,
// bus/stall behaviour is checked cycle by cycle.
module tb_boa_stage_mem;

  localparam logic [6:0] OpcLoad  = 7'b0000011;
  localparam logic [6:0] OpcStore = 7'b0100011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;

  typedef struct packed {
    logic [31:1] pc;
    logic [31:0] val;
    logic        chk_val;
    logic        trap;
    logic [3:0]  cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, clear;
  logic        d_valid, d_use_rd, d_trap;
  logic [31:1] d_pc;
  logic [31:0] d_insn, d_rs1_val, d_rs2_val;
  logic [3:0]  d_cause;
  logic        q_valid, q_use_rd, q_trap;
  logic [31:1] q_pc;
  logic [31:0] q_insn, q_rd_val;
  logic [3:0]  q_cause;
  logic        fw_stall_mem, ext_stall, fw_rd, stall_req;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rd_txn = 0;
  int   txn0;

  boa_stage_mem_if bus_if ();

  boa_stage_mem dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .d_valid      (d_valid),
    .d_pc         (d_pc),
    .d_insn       (d_insn),
    .d_use_rd     (d_use_rd),
    .d_rs1_val    (d_rs1_val),
    .d_rs2_val    (d_rs2_val),
    .d_trap       (d_trap),
    .d_cause      (d_cause),
    .q_valid      (q_valid),
    .q_pc         (q_pc),
    .q_insn       (q_insn),
    .q_use_rd     (q_use_rd),
    .q_rd_val     (q_rd_val),
    .q_trap       (q_trap),
    .q_cause      (q_cause),
    .bus          (bus_if),
    .fw_stall_mem (fw_stall_mem),
    .fw_rd        (fw_rd),
    .stall_req    (stall_req)
  );

  always #5 clk = ~clk;

  // Hazard unit stand-in: the stage's own stall request plus an injected downstream stall.
  assign fw_stall_mem = stall_req | ext_stall;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] opc);
    return {17'h00000, f3, 5'h00, opc};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] insn, input logic use_rd,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic trap, input logic [3:0] cause);
    d_valid   = 1'b1;
    d_pc      = pc[31:1];
    d_insn    = insn;
    d_use_rd  = use_rd;
    d_rs1_val = rs1;
    d_rs2_val = rs2;
    d_trap    = trap;
    d_cause   = cause;
  endtask

  task automatic bubble();
    d_valid = 1'b0;
    d_trap  = 1'b0;
  endtask

  task automatic expect_ret(input logic [31:0] pc, input logic [31:0] val, input logic chk_val,
                            input logic trap, input logic [3:0] cause);
    exp_t e;
    e.pc      = pc[31:1];
    e.val     = val;
    e.chk_val = chk_val;
    e.trap    = trap;
    e.cause   = cause;
    sb.push_back(e);
  endtask

  // Load that waits `waits` cycles for bus_ready, then returns `rdata`.
  task automatic load_wait(input string tag, input logic [31:0] pc, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] rdata, input int waits,
                           input logic [31:0] exp);
    issue(pc, mk(f3, OpcLoad), 1'b1, addr, 32'h0, 1'b0, 4'd0);
    expect_ret(pc, exp, 1'b1, 1'b0, 4'd0);
    cyc();
    bubble();
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < waits; i++) begin
      smp();
      check_val({tag, "_wait_stall"}, 32'(stall_req), 32'd1);
      check_val({tag, "_wait_re"}, 32'(bus_if.bus_re), 32'd1);
      check_val({tag, "_wait_qvalid"}, 32'(q_valid), 32'd0);
      cyc();
    end
    bus_if.bus_ready = 1'b1;
    bus_if.bus_rdata = rdata;
    smp();
    check_val({tag, "_done_stall"}, 32'(stall_req), 32'd0);
    check_val({tag, "_rd_val"}, q_rd_val, exp);
    check_val({tag, "_fw_rd"}, 32'(fw_rd), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus_if.bus_re && bus_if.bus_ready) n_rd_txn++;
    if (!rst && q_valid && !fw_stall_mem) begin
      if (sb.size() == 0) begin
        check_val("sb_unexpected_retire", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("ret_pc", 32'(q_pc), 32'(e.pc));
        if (e.chk_val) check_val("ret_rd_val", q_rd_val, e.val);
        check_val("ret_trap", 32'(q_trap), 32'(e.trap));
        check_val("ret_cause", 32'(q_cause), 32'(e.cause));
      end
    end
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    ext_stall = 1'b0;
    bubble();
    d_pc = '0;
    d_insn = '0;
    d_use_rd = 1'b0;
    d_rs1_val = '0;
    d_rs2_val = '0;
    d_cause = '0;
    bus_if.bus_ready = 1'b0;
    bus_if.bus_rdata = '0;

    repeat (3) cyc();
    smp();
    check_val("rst_qvalid", 32'(q_valid), 32'd0);
    check_val("rst_qtrap", 32'(q_trap), 32'd0);
    check_val("rst_re", 32'(bus_if.bus_re), 32'd0);
    check_val("rst_we", 32'(bus_if.bus_we), 32'd0);
    check_val("rst_stall", 32'(stall_req), 32'd0);
    cyc();
    rst = 1'b0;

    // SW, zero-latency bus
    issue(32'h1000, mk(3'b010, OpcStore), 1'b0, 32'h100, 32'hDEADBEEF, 1'b0, 4'd0);
    expect_ret(32'h1000, 32'h100, 1'b1, 1'b0, 4'd0);
    cyc();
    bubble();
    bus_if.bus_ready = 1'b1;
    smp();
    check_val("sw_we", 32'(bus_if.bus_we), 32'hF);
    check_val("sw_addr", 32'(bus_if.bus_addr), 32'h40);
    check_val("sw_wdata", bus_if.bus_wdata, 32'hDEADBEEF);
    check_val("sw_stall", 32'(stall_req), 32'd0);
    check_val("sw_qvalid", 32'(q_valid), 32'd1);

    load_wait("lb", 32'h1004, 3'b000, 32'h203, 32'h80FF0000, 3, 32'hFFFFFF80);
    load_wait("lbu", 32'h1008, 3'b100, 32'h203, 32'h80FF0000, 3, 32'h00000080);
    load_wait("lhu", 32'h100C, 3'b101, 32'h206, 32'h9ABC1234, 1, 32'h00009ABC);
    load_wait("lw0", 32'h1010, 3'b010, 32'h204, 32'h11223344, 0, 32'h11223344);

    // SH at odd halfword slot
    issue(32'h1014, mk(3'b001, OpcStore), 1'b0, 32'h102, 32'h00001234, 1'b0, 4'd0);
    expect_ret(32'h1014, 32'h102, 1'b1, 1'b0, 4'd0);
    cyc();
    bubble();
    bus_if.bus_ready = 1'b1;
    smp();
    check_val("sh_we", 32'(bus_if.bus_we), 32'hC);
    check_val("sh_wdata", bus_if.bus_wdata, 32'h12341234);

    // SB byte 1
    issue(32'h1018, mk(3'b000, OpcStore), 1'b0, 32'h101, 32'h000000A5, 1'b0, 4'd0);
    expect_ret(32'h1018, 32'h101, 1'b1, 1'b0, 4'd0);
    cyc();
    bubble();
    smp();
    check_val("sb_we", 32'(bus_if.bus_we), 32'h2);
    check_val("sb_wdata", bus_if.bus_wdata, 32'hA5A5A5A5);

    // Misaligned LW: trap, no bus access, no stall even with bus not ready
    issue(32'h101C, mk(3'b010, OpcLoad), 1'b1, 32'h102, 32'h0, 1'b0, 4'd0);
    expect_ret(32'h101C, 32'h0, 1'b0, 1'b1, 4'd4);
    cyc();
    bubble();
    bus_if.bus_ready = 1'b0;
    smp();
    check_val("lwmis_re", 32'(bus_if.bus_re), 32'd0);
    check_val("lwmis_stall", 32'(stall_req), 32'd0);
    check_val("lwmis_trap", 32'(q_trap), 32'd1);
    check_val("lwmis_cause", 32'(q_cause), 32'd4);

    // Misaligned SH
    issue(32'h1020, mk(3'b001, OpcStore), 1'b0, 32'h101, 32'h0, 1'b0, 4'd0);
    expect_ret(32'h1020, 32'h101, 1'b1, 1'b1, 4'd6);
    cyc();
    bubble();
    smp();
    check_val("shmis_we", 32'(bus_if.bus_we), 32'd0);
    check_val("shmis_cause", 32'(q_cause), 32'd6);

    // Illegal load funct3=011 (also misaligned-size-agnostic)
    issue(32'h1024, mk(3'b011, OpcLoad), 1'b1, 32'h0, 32'h0, 1'b0, 4'd0);
    expect_ret(32'h1024, 32'h0, 1'b0, 1'b1, 4'd2);
    cyc();
    bubble();
    smp();
    check_val("ill_re", 32'(bus_if.bus_re), 32'd0);
    check_val("ill_cause", 32'(q_cause), 32'd2);

    // LH completing under a 4-cycle downstream stall: single transaction, held data
    issue(32'h1028, mk(3'b001, OpcLoad), 1'b1, 32'h0, 32'h0, 1'b0, 4'd0);
    expect_ret(32'h1028, 32'hFFFF8001, 1'b1, 1'b0, 4'd0);
    cyc();
    bubble();
    ext_stall = 1'b1;
    bus_if.bus_ready = 1'b1;
    bus_if.bus_rdata = 32'h00018001;
    txn0 = n_rd_txn;
    smp();
    check_val("lhst_re0", 32'(bus_if.bus_re), 32'd1);
    check_val("lhst_val0", q_rd_val, 32'hFFFF8001);
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus_if.bus_rdata = 32'hFFFF0000 ^ 32'(i);
      smp();
      check_val("lhst_re_held", 32'(bus_if.bus_re), 32'd0);
      check_val("lhst_val_held", q_rd_val, 32'hFFFF8001);
      check_val("lhst_fw_rd", 32'(fw_rd), 32'd1);
    end
    cyc();
    ext_stall = 1'b0;
    smp();
    check_val("lhst_val_rel", q_rd_val, 32'hFFFF8001);
    check_val("lhst_txn_count", 32'(n_rd_txn - txn0), 32'd1);

    // clear mid-wait withdraws the request
    issue(32'h102C, mk(3'b010, OpcLoad), 1'b1, 32'h200, 32'h0, 1'b0, 4'd0);
    cyc();
    bubble();
    bus_if.bus_ready = 1'b0;
    smp();
    check_val("clr_pre_re", 32'(bus_if.bus_re), 32'd1);
    cyc();
    clear = 1'b1;
    smp();
    check_val("clr_re", 32'(bus_if.bus_re), 32'd0);
    check_val("clr_qvalid", 32'(q_valid), 32'd0);
    check_val("clr_qtrap", 32'(q_trap), 32'd0);
    check_val("clr_stall", 32'(stall_req), 32'd0);
    cyc();
    clear = 1'b0;

    // rst while in DONE
    issue(32'h1030, mk(3'b001, OpcLoad), 1'b1, 32'h0, 32'h0, 1'b0, 4'd0);
    cyc();
    bubble();
    ext_stall = 1'b1;
    bus_if.bus_ready = 1'b1;
    smp();
    check_val("rstd_re", 32'(bus_if.bus_re), 32'd1);
    cyc();
    rst = 1'b1;
    smp();
    check_val("rstd_done_re", 32'(bus_if.bus_re), 32'd0);
    cyc();
    rst = 1'b0;
    ext_stall = 1'b0;
    bus_if.bus_ready = 1'b0;
    smp();
    check_val("rstd_qvalid", 32'(q_valid), 32'd0);
    check_val("rstd_re_after", 32'(bus_if.bus_re), 32'd0);
    check_val("rstd_we_after", 32'(bus_if.bus_we), 32'd0);
    check_val("rstd_addr_after", 32'(bus_if.bus_addr), 32'd0);
    // A fresh load must request immediately, so the FSM is back in IDLE
    issue(32'h1034, mk(3'b010, OpcLoad), 1'b1, 32'h300, 32'h0, 1'b0, 4'd0);
    expect_ret(32'h1034, 32'h0BADF00D, 1'b1, 1'b0, 4'd0);
    cyc();
    bubble();
    smp();
    check_val("rstd_new_re", 32'(bus_if.bus_re), 32'd1);
    check_val("rstd_new_addr", 32'(bus_if.bus_addr), 32'hC0);
    cyc();
    bus_if.bus_ready = 1'b1;
    bus_if.bus_rdata = 32'h0BADF00D;
    smp();

    // ADDI carrying an upstream trap
    issue(32'h1038, mk(3'b000, OpcOpImm), 1'b1, 32'h55, 32'h0, 1'b1, 4'd3);
    expect_ret(32'h1038, 32'h55, 1'b1, 1'b1, 4'd3);
    cyc();
    bubble();
    smp();
    check_val("addi_re", 32'(bus_if.bus_re), 32'd0);
    check_val("addi_we", 32'(bus_if.bus_we), 32'd0);
    check_val("addi_val", q_rd_val, 32'h55);
    check_val("addi_trap", 32'(q_trap), 32'd1);
    check_val("addi_fw_rd", 32'(fw_rd), 32'd1);

    // Plain ADDI passes through
    issue(32'h103C, mk(3'b000, OpcOpImm), 1'b1, 32'h77, 32'h0, 1'b0, 4'd0);
    expect_ret(32'h103C, 32'h77, 1'b1, 1'b0, 4'd0);
    cyc();
    bubble();
    smp();
    check_val("addi2_trap", 32'(q_trap), 32'd0);

    cyc();
    smp();
    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
